// File: rtl/mux_rr_arb.sv
// mux_rr_arb: NUM_CH-input valid/ready arbitrating mux with round-robin or fixed-select grant.
// Latency: 1 cycle; a beat accepted at edge N is presented on the output after edge N.
// Backpressure: a stalled output beat (valid & !ready) drops every input ready until it drains.
// Option: define MUX_PKT_LOCK_EN to hold the grant on one channel until its last beat (ARB/LOCK FSM).
module mux_rr_arb #(
    parameter int  WIDTH  = 4,
    parameter int  NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mux_mode,
    input  logic [CH_W-1:0]         mux_sel,
    input  logic [NUM_CH*WIDTH-1:0] mux_in_data,
    input  logic [NUM_CH-1:0]       mux_in_valid,
    input  logic [NUM_CH-1:0]       mux_in_last,
    output logic [NUM_CH-1:0]       mux_in_ready,
    output logic [WIDTH-1:0]        mux_out_data,
    output logic                    mux_out_valid,
    output logic                    mux_out_last,
    output logic [CH_W-1:0]         mux_out_ch,
    input  logic                    mux_out_ready
);

    // Output register and arbitration state.
    logic [WIDTH-1:0] out_dat_q;
    logic             out_vld_q;
    logic             out_last_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [CH_W-1:0]  rr_ptr_q;

    // Arbitration results for the current cycle.
    logic             load_en;
    logic             sel_in_range;
    logic             rr_vld;
    logic [CH_W-1:0]  rr_idx;
    int               rr_j;
    logic             fix_vld;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_dat;
    logic             grant_last;
    logic             accept;
    logic             ptr_upd;
    logic [CH_W-1:0]  next_ptr;

`ifdef MUX_PKT_LOCK_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q;
    logic [CH_W-1:0] lock_ch_q;
`endif

    // The output register may take a new beat when it is empty or being drained this cycle.
    assign load_en = !out_vld_q || mux_out_ready;

    // A select value past the last channel (only possible for non-power-of-two NUM_CH) grants nothing.
    assign sel_in_range = (int'(mux_sel) < NUM_CH);
    assign fix_vld      = sel_in_range && mux_in_valid[mux_sel];

    // Round-robin search: first valid channel at or above rr_ptr, wrapping past NUM_CH-1 to 0.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        rr_j   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            rr_j = int'(rr_ptr_q) + k;
            if (rr_j >= NUM_CH) begin
                rr_j = rr_j - NUM_CH;
            end
            if (!rr_vld && mux_in_valid[CH_W'(rr_j)]) begin
                rr_vld = 1'b1;
                rr_idx = CH_W'(rr_j);
            end
        end
    end

    // Grant selection: packet lock (when built in) overrides the mode, then fixed or round-robin.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef MUX_PKT_LOCK_EN
        if (state_q == ST_LOCK) begin
            grant_vld = mux_in_valid[lock_ch_q];
            grant_idx = lock_ch_q;
        end else
`endif
        if (mux_mode) begin
            grant_vld = fix_vld;
            grant_idx = mux_sel;
        end else begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
    end

    assign grant_dat  = mux_in_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign grant_last = mux_in_last[grant_idx];
    assign accept     = grant_vld && load_en;
    assign next_ptr   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    // Ready is the one-hot grant gated by output space; never more than one bit high.
    always_comb begin
        mux_in_ready = '0;
        if (accept) begin
            mux_in_ready[grant_idx] = 1'b1;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // Pointer only moves once a packet completes, so a locked packet does not skew fairness.
    assign ptr_upd = accept && grant_last;

    // ARB/LOCK FSM: a non-last beat pins the grant to its channel until that channel's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARB;
            lock_ch_q <= '0;
        end else if (accept) begin
            case (state_q)
                ST_ARB: begin
                    if (!grant_last) begin
                        state_q   <= ST_LOCK;
                        lock_ch_q <= grant_idx;
                    end
                end
                ST_LOCK: begin
                    if (grant_last) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end
`else
    // Per-beat arbitration: every accepted beat moves the pointer past its channel.
    assign ptr_upd = accept;
`endif

    // Round-robin pointer: one past the channel that last won, in either mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (ptr_upd) begin
            rr_ptr_q <= next_ptr;
        end
    end

    // Output register: load the granted beat, or go empty when draining with nothing granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            out_ch_q   <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= grant_dat;
                out_last_q <= grant_last;
                out_ch_q   <= grant_idx;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign mux_out_data  = out_dat_q;
    assign mux_out_valid = out_vld_q;
    assign mux_out_last  = out_last_q;
    assign mux_out_ch    = out_ch_q;

    // Structural invariants: ready is one-hot-or-zero and fully blocked during an output stall.
    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(mux_in_ready));
    a_stall_no_rdy : assert property (@(posedge clk) disable iff (!rst_n)
        (mux_out_valid && !mux_out_ready) |-> (mux_in_ready == '0));

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: randomized + directed bench for mux_rr_arb with a behavioural reference model.
// Latency: model predicts the output register contents one edge after acceptance.
// Backpressure: model gates its expected ready with output-space availability.
module tb_mux_rr_arb;

    localparam int NC = 4;
    localparam int W  = 4;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [1:0]    sel;
    logic [15:0]   in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [3:0]    in_ready;
    logic [3:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic [1:0]    out_ch;
    logic          out_ready;

    // Second instance with a non-power-of-two channel count to reach an out-of-range select.
    logic          mode2;
    logic [1:0]    sel2;
    logic [11:0]   in_data2;
    logic [2:0]    in_valid2;
    logic [2:0]    in_last2;
    logic [2:0]    in_ready2;
    logic [3:0]    out_data2;
    logic          out_valid2;
    logic          out_last2;
    logic [1:0]    out_ch2;
    logic          out_ready2;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_arb #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mux_mode      (mode),
        .mux_sel       (sel),
        .mux_in_data   (in_data),
        .mux_in_valid  (in_valid),
        .mux_in_last   (in_last),
        .mux_in_ready  (in_ready),
        .mux_out_data  (out_data),
        .mux_out_valid (out_valid),
        .mux_out_last  (out_last),
        .mux_out_ch    (out_ch),
        .mux_out_ready (out_ready)
    );

    mux_rr_arb #(.WIDTH(W), .NUM_CH(3)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mux_mode      (mode2),
        .mux_sel       (sel2),
        .mux_in_data   (in_data2),
        .mux_in_valid  (in_valid2),
        .mux_in_last   (in_last2),
        .mux_in_ready  (in_ready2),
        .mux_out_data  (out_data2),
        .mux_out_valid (out_valid2),
        .mux_out_last  (out_last2),
        .mux_out_ch    (out_ch2),
        .mux_out_ready (out_ready2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so the model at negedge sees final values.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Output holding register, pointer = channel after the last winner, optional packet lock.
    bit       m_vld;
    bit [3:0] m_data;
    bit       m_last;
    int       m_ch;
    int       m_ptr;
    bit       m_locked;
    int       m_lock_ch;
    bit       e_gv;
    int       e_g;
    bit       e_load;
    logic [3:0] e_rdy;
    int       best_d;
    int       dd;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_vld     = 1'b0;
            m_data    = '0;
            m_last    = 1'b0;
            m_ch      = 0;
            m_ptr     = 0;
            m_locked  = 1'b0;
            m_lock_ch = 0;
        end else begin
            e_gv = 1'b0;
            e_g  = 0;
            if (m_locked) begin
                e_gv = in_valid[m_lock_ch];
                e_g  = m_lock_ch;
            end else if (mode) begin
                if (int'(sel) < NC && in_valid[sel]) begin
                    e_gv = 1'b1;
                    e_g  = int'(sel);
                end
            end else begin
                // Winner is the valid channel at the smallest forward distance from the pointer.
                best_d = NC;
                for (int i = 0; i < NC; i++) begin
                    if (in_valid[i]) begin
                        dd = (i - m_ptr + NC) % NC;
                        if (dd < best_d) begin
                            best_d = dd;
                            e_g    = i;
                        end
                    end
                end
                e_gv = (best_d < NC);
            end
            e_load = !m_vld || out_ready;
            e_rdy  = (e_gv && e_load) ? 4'(1 << e_g) : 4'b0000;

            chk("mdl_ready", 32'(in_ready), 32'(e_rdy));
            chk("mdl_out_valid", 32'(out_valid), 32'(m_vld));
            if (m_vld) begin
                chk("mdl_out_data", 32'(out_data), 32'(m_data));
                chk("mdl_out_last", 32'(out_last), 32'(m_last));
                chk("mdl_out_ch", 32'(out_ch), 32'(m_ch));
            end

            if (e_load) begin
                if (e_gv) begin
                    m_vld  = 1'b1;
                    m_data = in_data[e_g*W +: W];
                    m_last = in_last[e_g];
                    m_ch   = e_g;
`ifdef MUX_PKT_LOCK_EN
                    if (!in_last[e_g]) begin
                        m_locked  = 1'b1;
                        m_lock_ch = e_g;
                    end else begin
                        m_locked = 1'b0;
                        m_ptr    = (e_g + 1) % NC;
                    end
`else
                    m_ptr = (e_g + 1) % NC;
`endif
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    // Lock scenario: ch1 valid pattern, ch1 last pattern, expected output valid/ch after each edge.
    logic [3:0] lk_valid [5] = '{4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b0100};
    logic       lk_last1 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef MUX_PKT_LOCK_EN
    logic       lk_ev    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int         lk_ech   [5] = '{1, 1, 0, 1, 2};
`else
    logic       lk_ev    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int         lk_ech   [5] = '{1, 2, 2, 1, 2};
`endif

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = '0;
        in_data    = '0;
        in_valid   = '0;
        in_last    = '0;
        out_ready  = 1'b0;
        mode2      = 1'b1;
        sel2       = 2'd3;
        in_data2   = 12'h321;
        in_valid2  = 3'b111;
        in_last2   = 3'b111;
        out_ready2 = 1'b1;

        // Reset state.
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_ch", 32'(out_ch), 0);

        // Release reset; channel 0 is granted in the first cycle.
        rst_n     = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = 16'h4321;
        out_ready = 1'b1;
        #1;
        chk("rst_first_ready", 32'(in_ready), 32'b0001);

        // Round-robin fairness: 0,1,2,3,0,... one beat per cycle.
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_ch", 32'(out_ch), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'(k % 4 + 1));
            if (k == 3 || k == 7) begin
                chk("oor_ready", 32'(in_ready2), 0);
                chk("oor_valid", 32'(out_valid2), 0);
            end
        end

        // Fixed select channel 2.
        mode = 1'b1;
        sel  = 2'd2;
        sel2 = 2'd2;
        #1;
        chk("fix_ready", 32'(in_ready), 32'b0100);
        chk("fix3_ready", 32'(in_ready2), 32'b100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fix_ch", 32'(out_ch), 2);
            chk("fix_data", 32'(out_data), 3);
        end
        chk("fix3_ch", 32'(out_ch2), 2);
        chk("fix3_data", 32'(out_data2), 3);

        // Backpressure: load 0xA from ch1, then stall three cycles.
        sel      = 2'd1;
        in_valid = 4'b0010;
        in_data  = 16'h43A1;
        tick();
        chk("bp_load_ch", 32'(out_ch), 1);
        chk("bp_load_data", 32'(out_data), 32'hA);
        out_ready = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", 32'(out_data), 32'hA);
            chk("bp_hold_ch", 32'(out_ch), 1);
            chk("bp_hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_ch", 32'(out_ch), 2);
        chk("bp_next_data", 32'(out_data), 3);

        // Sparse round-robin: set pointer to 1 via ch0, then only ch3 and ch0 valid.
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 4'b0001;
        in_data  = 16'h4321;
        tick();
        chk("sp_seed_ch", 32'(out_ch), 0);
        mode     = 1'b0;
        in_valid = 4'b1001;
        #1;
        chk("sp_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("sp_first_ch", 32'(out_ch), 3);
        tick();
        chk("sp_second_ch", 32'(out_ch), 0);

        // Packet scenario: ch1 three beats with a one-cycle gap, ch2 valid throughout.
        for (int k = 0; k < 5; k++) begin
            in_valid = lk_valid[k];
            in_last  = {2'b11, lk_last1[k], 1'b1};
            tick();
            chk("pkt_valid", 32'(out_valid), 32'(lk_ev[k]));
            if (lk_ev[k]) begin
                chk("pkt_ch", 32'(out_ch), 32'(lk_ech[k]));
            end
        end

        // Asynchronous reset while holding a (locked) beat under stall.
        in_valid = 4'b0010;
        in_last  = 4'b1101;
        #1;
        chk("ar_pre_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("ar_pre_valid", 32'(out_valid), 1);
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_out_data", 32'(out_data), 0);
        chk("ar_out_ch", 32'(out_ch), 0);
        chk("ar_out_last", 32'(out_last), 0);
        tick();
        rst_n     = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        #1;
        chk("ar_first_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("ar_first_ch", 32'(out_ch), 0);
        chk("ar_first_data", 32'(out_data), 1);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) == 0) ? 4'($urandom & $urandom) : 4'($urandom);
            in_data   = 16'($urandom);
            in_last   = 4'($urandom | $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                mode = ~mode;
            end
            if ($urandom_range(0, 7) == 0) begin
                sel = 2'($urandom);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
